// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, forwarding select codes and RAW helper for the pipeline controller
package pipe_ctrl_pkg;
  localparam int REG_ADDR_W = 2;
  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_e;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  function automatic logic raw_hit(
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic                  use1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use2
  );
    return (use1 & (rd == rs1)) | (use2 & (rd == rs2));
  endfunction
endpackage

// File: rtl/pipe_fwd_unit.sv
// pipe_fwd_unit: EX operand forward select; ex_rs_i vs MEM/WB destinations -> fwd_o (MEM wins over WB)
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  output logic [1:0]            fwd_o
);
  assign fwd_o = (mem_regwrite_i & (mem_rd_i == ex_rs_i)) ? FWD_EXMEM :
                 (wb_regwrite_i & (wb_rd_i == ex_rs_i))   ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enables/flushes, load-use stall, memory-wait freeze with timeout, forward selects
// Inputs: ID/EX/MEM/WB register ids and write flags, mem_req/mem_ready, branch_taken; reset is sync active-low.
// Outputs: pc/stage enables, IF/ID and ID/EX flushes, fwd_a/fwd_b, sticky mem_timeout, saturating stall_cnt.
// Macro PIPE_HAZARD_CTRL_FWD_EN enables forwarding (stall becomes load-use only).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rs1,
  input  logic [REG_ADDR_W-1:0]  ex_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [REG_ADDR_W-1:0]  mem_rd,
  input  logic                   mem_regwrite,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic [REG_ADDR_W-1:0]  wb_rd,
  input  logic                   wb_regwrite,
  input  logic                   branch_taken,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  state_e                 state_q, state_d;
  logic [7:0]             wait_q, wait_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   mstall, hazard, run, hold;
  always_comb begin
    mstall = mem_req & ~mem_ready;
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    hazard = ex_memread & ex_regwrite & raw_hit(ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);
`else
    // without forwarding any in-flight producer blocks the consumer until it retires
    hazard = (ex_regwrite  & raw_hit(ex_rd,  id_rs1, id_use_rs1, id_rs2, id_use_rs2)) |
             (mem_regwrite & raw_hit(mem_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2)) |
             (wb_regwrite  & raw_hit(wb_rd,  id_rs1, id_use_rs1, id_rs2, id_use_rs2));
`endif
    // run: pipe may advance this cycle (MEM_WAIT with mem_ready behaves as RUN)
    run = reset & (state_q != TIMEOUT) & ~mstall;
    hold = run & ~branch_taken & hazard;
    pc_en = run & ~hold;
    if_id_en = run & ~hold;
    id_ex_en = run;
    ex_mem_en = run;
    mem_wb_en = run;
    if_id_flush = run & branch_taken;
    id_ex_flush = run & (branch_taken | hazard);
    mem_timeout = reset & (state_q == TIMEOUT);
    state_d = (state_q == TIMEOUT) ? TIMEOUT :
              !mstall ? RUN :
              (({1'b0, wait_q} + 9'd1) >= 9'(MEM_TIMEOUT)) ? TIMEOUT : MEM_WAIT;
    wait_d = (state_q == TIMEOUT) ? wait_q : mstall ? wait_q + 8'd1 : 8'd0;
    stall_d = (~pc_en & ~&stall_q) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      stall_q <= stall_d;
    end
  end
  assign stall_cnt = stall_q;
`ifdef PIPE_HAZARD_CTRL_FWD_EN
  logic [1:0] fwd_a_w, fwd_b_w;
  pipe_fwd_unit u_fwd_a (
    .ex_rs_i(ex_rs1), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .fwd_o(fwd_a_w)
  );
  pipe_fwd_unit u_fwd_b (
    .ex_rs_i(ex_rs2), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .fwd_o(fwd_b_w)
  );
  assign fwd_a = reset ? fwd_a_w : FWD_RF;
  assign fwd_b = reset ? fwd_b_w : FWD_RF;
`else
  logic unused_ok;
  assign unused_ok = ^{ex_rs1, ex_rs2, ex_memread};
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random stimulus against a cycle-level behavioural model
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 15;
  localparam int STALL_CNT_W = 8;
  localparam int STALL_MAX = (1 << STALL_CNT_W) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite;
  logic mem_req, mem_ready, wb_regwrite, branch_taken;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [STALL_CNT_W-1:0] stall_cnt;
  int checks = 0;
  int failures = 0;
  bit m_to;
  int m_wait, m_stall;
  logic [6:0] e_ctl;
  logic [1:0] e_fa, e_fb;
  logic e_to;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic bit reads(input logic [1:0] rd);
    return (id_use_rs1 && rd == id_rs1) || (id_use_rs2 && rd == id_rs2);
  endfunction
  function automatic bit hazard();
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    return ex_memread && ex_regwrite && reads(ex_rd);
`else
    return (ex_regwrite && reads(ex_rd)) || (mem_regwrite && reads(mem_rd)) || (wb_regwrite && reads(wb_rd));
`endif
  endfunction
  function automatic logic [1:0] fwd(input logic [1:0] rs);
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    if (mem_regwrite && mem_rd == rs) return 2'b01;
    if (wb_regwrite && wb_rd == rs) return 2'b10;
`endif
    return 2'b00;
  endfunction
  // control vector order: pc, if_id, id_ex, ex_mem, mem_wb enables, then if_id, id_ex flushes
  task automatic predict();
    bit mst;
    mst = mem_req && !mem_ready;
    e_fa = reset ? fwd(ex_rs1) : 2'b00;
    e_fb = reset ? fwd(ex_rs2) : 2'b00;
    e_to = reset && m_to;
    if (!reset || m_to || mst) e_ctl = 7'b00000_00;
    else if (branch_taken) e_ctl = 7'b11111_11;
    else if (hazard()) e_ctl = 7'b00111_01;
    else e_ctl = 7'b11111_00;
  endtask
  task automatic step(input string tag);
    @(negedge clk);
    predict();
    chk({tag, ".ctl"}, {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}, e_ctl);
    chk({tag, ".fwd_a"}, fwd_a, e_fa);
    chk({tag, ".fwd_b"}, fwd_b, e_fb);
    chk({tag, ".timeout"}, mem_timeout, e_to);
    chk({tag, ".stall_cnt"}, stall_cnt, 32'(m_stall));
    @(posedge clk);
    if (!reset) begin
      m_to = 0;
      m_wait = 0;
      m_stall = 0;
    end else begin
      if (!e_ctl[6] && m_stall < STALL_MAX) m_stall++;
      if (!m_to) begin
        if (mem_req && !mem_ready) begin
          m_wait++;
          if (m_wait >= MEM_TIMEOUT) m_to = 1;
        end else m_wait = 0;
      end
    end
    #1;
  endtask
  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite} = '0;
    {mem_req, mem_ready, wb_regwrite, branch_taken} = '0;
  endtask
  task automatic load_use();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 2; id_rs1 = 2; id_use_rs1 = 1;
  endtask
  initial begin
    idle();
    m_to = 0; m_wait = 0; m_stall = 0;
    @(posedge clk);
    #1;
    repeat (3) step("rst");
    reset = 1;
    step("free");
    load_use();
    step("lu");
    idle();
    step("lu_after");
    mem_req = 1;
    repeat (4) step("mw");
    mem_ready = 1;
    step("mw_done");
    idle();
    step("mw_run");
    mem_req = 1;
    repeat (20) step("to");
    mem_ready = 1;
    repeat (3) step("to_hold");
    repeat (300) step("to_sat");
    reset = 0;
    step("to_rst");
    reset = 1;
    idle();
    step("to_clr");
    load_use();
    branch_taken = 1;
    step("br_lu");
    mem_req = 1;
    step("br_ms");
    idle();
    step("br_done");
    mem_rd = 1; wb_rd = 1; mem_regwrite = 1; wb_regwrite = 1; ex_rs1 = 1;
    step("fwd_mem");
    mem_regwrite = 0;
    step("fwd_wb");
    repeat (3000) begin
      {id_rs1, id_rs2, ex_rs1, ex_rs2} = 8'($urandom);
      {ex_rd, mem_rd, wb_rd} = 6'($urandom);
      {id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite} = 6'($urandom);
      branch_taken = ($urandom_range(0, 3) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 1) == 0);
      reset = ($urandom_range(0, 199) != 0);
      step("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
